// File: rtl/gp_lpddr5_cmd_scheduler.sv
// gp_lpddr5_cmd_scheduler: single-rank, single-bank LPDDR5 open-page command sequencer.
// Define GP_LPDDR5_SCHED_CAS_SYNC_EN to emit CAS_WR/CAS_RD ahead of each WR16/RD16.
module gp_lpddr5_cmd_scheduler #(
  parameter int T_RCD  = 4,
  parameter int T_RP   = 3,
  parameter int T_RFC  = 8,
  parameter int T_REFI = 64
) (
  input  logic       ck_t,
  input  logic       ddr_reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_op,
  input  logic [7:0] req_row,
  input  logic [3:0] req_col,
  output logic       cs,
  output logic [6:0] ca,
  output logic       rw_issue,
  output logic       rw_op,
  output logic       row_open,
  output logic       ref_busy,
  output logic       ref_overrun
);

  localparam int WW  = $clog2(T_RCD + T_RP + T_RFC + 2);
  localparam int RIW = $clog2(T_REFI);

  localparam logic [WW-1:0]  W_ONE    = {{(WW-1){1'b0}}, 1'b1};
  localparam logic [WW-1:0]  RCD_LD   = WW'(T_RCD - 2);
  localparam logic [WW-1:0]  RP_LD    = WW'(T_RP - 2);
  localparam logic [WW-1:0]  RFC_LD   = WW'(T_RFC - 2);
  localparam logic [RIW-1:0] RI_ONE   = {{(RIW-1){1'b0}}, 1'b1};
  localparam logic [RIW-1:0] REFI_MAX = RIW'(T_REFI - 1);

  localparam logic [6:0] CA_PRE   = 7'b0001111;
  localparam logic [6:0] CA_REF   = 7'b0001110;
  localparam logic [6:0] CA_CASWR = 7'b0011100;
  localparam logic [6:0] CA_CASRD = 7'b0011010;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_TRP,
    S_ACT1,
    S_ACT2,
    S_TRCD,
    S_CAS,
    S_RW,
    S_REF,
    S_TRFC
  } state_t;

`ifdef GP_LPDDR5_SCHED_CAS_SYNC_EN
  localparam state_t S_GO = S_CAS;
`else
  localparam state_t S_GO = S_RW;
`endif

  state_t         state;
  state_t         state_nxt;
  logic [WW-1:0]  wcnt;
  logic [WW-1:0]  wcnt_nxt;
  logic [RIW-1:0] refi_cnt;
  logic           ref_pending;
  logic [7:0]     row_q;
  logic [3:0]     col_q;

  logic           hs;
  logic           hit;
  logic           wrap;
  logic           ref_issue;
  logic           pend_nxt;
  logic           busy_nxt;
  logic           open_nxt;
  logic [7:0]     row_c;
  logic [3:0]     col_c;
  logic           op_c;
  logic           cmd_cs;
  logic [6:0]     cmd_ca;

  assign hs    = req_valid & req_ready;
  assign hit   = row_open && (row_q == req_row);
  assign wrap  = (refi_cnt == REFI_MAX);
  assign row_c = hs ? req_row : row_q;
  assign col_c = hs ? req_col : col_q;
  assign op_c  = hs ? req_op : rw_op;

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    unique case (state)
      S_IDLE: begin
        if (ref_pending)
          state_nxt = row_open ? S_PRE : S_REF;
        else if (hs)
          state_nxt = hit ? S_GO : (row_open ? S_PRE : S_ACT1);
      end
      S_PRE: begin
        if (T_RP == 1) begin
          state_nxt = ref_busy ? S_REF : S_ACT1;
        end else begin
          state_nxt = S_TRP;
          wcnt_nxt  = RP_LD;
        end
      end
      S_TRP: begin
        if (wcnt == '0)
          state_nxt = ref_busy ? S_REF : S_ACT1;
        else
          wcnt_nxt = wcnt - W_ONE;
      end
      S_ACT1: state_nxt = S_ACT2;
      S_ACT2: begin
        if (T_RCD == 1) begin
          state_nxt = S_GO;
        end else begin
          state_nxt = S_TRCD;
          wcnt_nxt  = RCD_LD;
        end
      end
      S_TRCD: begin
        if (wcnt == '0)
          state_nxt = S_GO;
        else
          wcnt_nxt = wcnt - W_ONE;
      end
      S_CAS: state_nxt = S_RW;
      S_RW:  state_nxt = S_IDLE;
      S_REF: begin
        if (T_RFC == 1) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_TRFC;
          wcnt_nxt  = RFC_LD;
        end
      end
      S_TRFC: begin
        if (wcnt == '0)
          state_nxt = S_IDLE;
        else
          wcnt_nxt = wcnt - W_ONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A wrap coinciding with REF issue re-arms the request instead of dropping it.
  assign ref_issue = (state_nxt == S_REF);
  assign pend_nxt  = wrap | (ref_pending & ~ref_issue);

  always_comb begin
    busy_nxt = 1'b0;
    unique case (state_nxt)
      S_IDLE:        busy_nxt = pend_nxt;
      S_PRE, S_TRP:  busy_nxt = ref_busy | (ref_pending & (state == S_IDLE));
      S_REF, S_TRFC: busy_nxt = 1'b1;
      default:       busy_nxt = 1'b0;
    endcase
  end

  always_comb begin
    open_nxt = row_open;
    if (state_nxt == S_PRE)
      open_nxt = 1'b0;
    else if (state_nxt == S_ACT2)
      open_nxt = 1'b1;
  end

  always_comb begin
    cmd_cs = 1'b1;
    cmd_ca = '0;
    unique case (state_nxt)
      S_PRE:   cmd_ca = CA_PRE;
      S_ACT1:  cmd_ca = {3'b111, row_c[7:4]};
      S_ACT2:  cmd_ca = {3'b110, row_c[3:0]};
      S_CAS:   cmd_ca = op_c ? CA_CASWR : CA_CASRD;
      S_RW:    cmd_ca = op_c ? {3'b011, col_c} : {3'b100, col_c};
      S_REF:   cmd_ca = CA_REF;
      default: cmd_cs = 1'b0;
    endcase
  end

  always_ff @(posedge ck_t or negedge ddr_reset_n) begin
    if (!ddr_reset_n) begin
      state       <= S_IDLE;
      wcnt        <= '0;
      refi_cnt    <= '0;
      ref_pending <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      req_ready   <= 1'b0;
      cs          <= 1'b0;
      ca          <= '0;
      rw_issue    <= 1'b0;
      rw_op       <= 1'b0;
      row_open    <= 1'b0;
      ref_busy    <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      refi_cnt    <= wrap ? '0 : refi_cnt + RI_ONE;
      ref_pending <= pend_nxt;
      ref_overrun <= ref_overrun | (wrap & ref_pending & ~ref_issue);
      req_ready   <= (state_nxt == S_IDLE) && !pend_nxt;
      cs          <= cmd_cs;
      ca          <= cmd_ca;
      rw_issue    <= (state_nxt == S_RW);
      row_open    <= open_nxt;
      ref_busy    <= busy_nxt;
      if (hs) begin
        row_q <= req_row;
        col_q <= req_col;
        rw_op <= req_op;
      end
    end
  end

endmodule

// File: tb/tb_gp_lpddr5_cmd_scheduler.sv
// tb_gp_lpddr5_cmd_scheduler: directed checks of command sequencing,
// refresh insertion, overrun flag and asynchronous reset.
module tb_gp_lpddr5_cmd_scheduler;

  localparam int T_RCD  = 4;
  localparam int T_RP   = 3;
  localparam int T_RFC  = 8;
  localparam int T_REFI = 64;
`ifdef GP_LPDDR5_SCHED_CAS_SYNC_EN
  localparam int C = 1;
`else
  localparam int C = 0;
`endif

  localparam logic [6:0] CA_PRE   = 7'b0001111;
  localparam logic [6:0] CA_REF   = 7'b0001110;
  localparam logic [6:0] CA_CASWR = 7'b0011100;
  localparam logic [6:0] CA_CASRD = 7'b0011010;

  logic       ck_t = 1'b0;
  logic       ddr_reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_op = 1'b0;
  logic [7:0] req_row = '0;
  logic [3:0] req_col = '0;
  logic       req_ready, cs, rw_issue, rw_op;
  logic       row_open, ref_busy, ref_overrun;
  logic [6:0] ca;

  logic       v2 = 1'b0;
  logic       rdy2, cs2, rwi2, rwo2, ro2, rb2, ovr2;
  logic [6:0] ca2;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int cas_seen = 0;
  int n_req = 0;
  int rw_idx, rw_cyc;

  logic [6:0] t_ca [64];
  logic       t_cs [64];
  logic       t_op [64];
  logic       t_ro [64];

  always #5 ck_t = ~ck_t;

  always @(posedge ck_t) cyc++;

  always @(negedge ck_t)
    if (ca == CA_CASWR || ca == CA_CASRD) cas_seen++;

  gp_lpddr5_cmd_scheduler #(
    .T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC), .T_REFI(T_REFI)
  ) dut (
    .ck_t(ck_t), .ddr_reset_n(ddr_reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_row(req_row), .req_col(req_col),
    .cs(cs), .ca(ca), .rw_issue(rw_issue), .rw_op(rw_op),
    .row_open(row_open), .ref_busy(ref_busy),
    .ref_overrun(ref_overrun)
  );

  gp_lpddr5_cmd_scheduler #(
    .T_RCD(40), .T_RP(3), .T_RFC(8), .T_REFI(16)
  ) dut_ovr (
    .ck_t(ck_t), .ddr_reset_n(ddr_reset_n),
    .req_valid(v2), .req_ready(rdy2),
    .req_op(1'b1), .req_row(8'h77), .req_col(4'h1),
    .cs(cs2), .ca(ca2), .rw_issue(rwi2), .rw_op(rwo2),
    .row_open(ro2), .ref_busy(rb2), .ref_overrun(ovr2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic op, input logic [7:0] row,
                      input logic [3:0] col, input int stop);
    int  k;
    bit  done;
    k = 0;
    @(negedge ck_t);
    while (!req_ready && k < 200) begin
      @(negedge ck_t);
      k++;
    end
    chk("req_wait", req_ready, 1);
    req_op = op;
    req_row = row;
    req_col = col;
    req_valid = 1'b1;
    @(negedge ck_t);
    req_valid = 1'b0;
    rw_idx = 0;
    done = 1'b0;
    k = 1;
    while (!done) begin
      t_ca[k] = ca;
      t_cs[k] = cs;
      t_op[k] = rw_op;
      if (rw_issue) begin
        rw_idx = k;
        rw_cyc = cyc;
        n_req++;
        done = 1'b1;
      end else if (k == stop || k == 63) begin
        done = 1'b1;
      end else begin
        @(negedge ck_t);
        k++;
      end
    end
    if (stop == 0) chk("rw_seen", rw_idx != 0, 1);
  endtask

  task automatic wait_ref(output int bn, output int rb,
                          output int ri, output int rc);
    int k;
    k = 0;
    bn = 0;
    rb = 0;
    ri = -1;
    rc = 0;
    while (!ref_busy && k < 300) begin
      @(negedge ck_t);
      k++;
    end
    chk("ref_wait", ref_busy, 1);
    while (ref_busy && bn < 40) begin
      t_ca[bn] = ca;
      t_cs[bn] = cs;
      t_ro[bn] = row_open;
      if (req_ready) rb++;
      if (cs && ca == CA_REF) begin
        ri = bn;
        rc = cyc;
      end
      bn++;
      @(negedge ck_t);
    end
  endtask

  initial begin
    int prev, bn, rb, ri, rc, rc2, k;

    repeat (3) @(negedge ck_t);
    chk("rst_ready", req_ready, 0);
    chk("rst_cs_ca", {cs, ca}, 0);
    chk("rst_flags", {rw_issue, rw_op, row_open, ref_busy, ref_overrun}, 0);
    ddr_reset_n = 1'b1;
    @(negedge ck_t);
    chk("rel_ready", req_ready, 1);

    // row closed read
    send(1'b0, 8'h5A, 4'h3, 0);
    chk("cl_act1", {t_cs[1], t_ca[1]}, {1'b1, 7'b1110101});
    chk("cl_act2", {t_cs[2], t_ca[2]}, {1'b1, 7'b1101010});
    chk("cl_trcd_idle", {t_cs[3], t_ca[3]}, 0);
    chk("cl_cas", t_ca[2+T_RCD], C ? CA_CASRD : 7'b1000011);
    chk("cl_rw_idx", rw_idx, 2 + T_RCD + C);
    chk("cl_rd16", t_ca[rw_idx], 7'b1000011);
    chk("cl_op", t_op[rw_idx], 0);
    chk("cl_open", row_open, 1);

    // row hit write
    send(1'b1, 8'h5A, 4'h7, 0);
    chk("hit_cmd1", t_ca[1], C ? CA_CASWR : 7'b0110111);
    chk("hit_rw_idx", rw_idx, 1 + C);
    chk("hit_wr16", t_ca[rw_idx], 7'b0110111);
    chk("hit_op", t_op[rw_idx], 1);

    // back-to-back row hits
    send(1'b0, 8'h5A, 4'h1, 0);
    prev = rw_cyc;
    chk("b2b_rd16", t_ca[rw_idx], 7'b1000001);
    chk("b2b_op0", t_op[rw_idx], 0);
    send(1'b1, 8'h5A, 4'h2, 0);
    chk("b2b_space", rw_cyc - prev, 2 + C);
    chk("b2b_wr16", t_ca[rw_idx], 7'b0110010);

    // row conflict write
    send(1'b1, 8'h21, 4'h0, 0);
    chk("cf_pre", {t_cs[1], t_ca[1]}, {1'b1, CA_PRE});
    chk("cf_trp_idle", t_cs[2], 0);
    chk("cf_act1", t_ca[1+T_RP], 7'b1110010);
    chk("cf_act2", t_ca[2+T_RP], 7'b1100001);
    chk("cf_cas", t_ca[2+T_RP+T_RCD], C ? CA_CASWR : 7'b0110000);
    chk("cf_rw_idx", rw_idx, 2 + T_RP + T_RCD + C);
    chk("cf_wr16", t_ca[rw_idx], 7'b0110000);
    chk("cf_open", row_open, 1);

    // refresh with a row open
    wait_ref(bn, rb, ri, rc);
    chk("rfo_busy_len", bn, 1 + T_RP + T_RFC);
    chk("rfo_ready_low", rb, 0);
    chk("rfo_open_before", t_ro[0], 1);
    chk("rfo_pre", {t_cs[1], t_ca[1]}, {1'b1, CA_PRE});
    chk("rfo_closed", t_ro[1], 0);
    chk("rfo_ref_idx", ri, 1 + T_RP);
    chk("rfo_ready_back", req_ready, 1);

    // idle refreshes
    wait_ref(bn, rb, ri, rc);
    chk("rf_busy_len", bn, 1 + T_RFC);
    chk("rf_ready_low", rb, 0);
    chk("rf_ref_idx", ri, 1);
    chk("rf_ready_back", req_ready, 1);
    wait_ref(bn, rb, ri, rc2);
    chk("rf_interval", rc2 - rc, T_REFI);

    // reset during TRCD_WAIT
    send(1'b0, 8'h33, 4'h4, 0);
    chk("r33_rw_idx", rw_idx, 2 + T_RCD + C);
    send(1'b0, 8'h44, 4'h5, 2 + T_RP + 1);
    chk("trcd_pre", t_ca[1], CA_PRE);
    chk("trcd_open", row_open, 1);
    #1 ddr_reset_n = 1'b0;
    #1;
    chk("arst_out", {req_ready, cs, ca, row_open, rw_issue}, 0);
    @(negedge ck_t);
    ddr_reset_n = 1'b1;
    @(negedge ck_t);
    chk("arst_ready", req_ready, 1);

    k = 0;
    while (!rdy2 && k < 100) begin
      @(negedge ck_t);
      k++;
    end
    chk("ovr_req_wait", rdy2, 1);
    v2 = 1'b1;
    @(negedge ck_t);
    v2 = 1'b0;

    send(1'b0, 8'h44, 4'h5, 0);
    chk("post_act1", {t_cs[1], t_ca[1]}, {1'b1, 7'b1110100});
    chk("post_rw_idx", rw_idx, 2 + T_RCD + C);
    chk("post_rd16", t_ca[rw_idx], 7'b1000101);

    // overrun on the long-tRCD instance
    k = 0;
    while (!rwi2 && k < 100) begin
      @(negedge ck_t);
      k++;
    end
    chk("ovr_rw", rwi2, 1);
    chk("ovr_set", ovr2, 1);
    chk("ovr_main_clear", ref_overrun, 0);
    repeat (40) @(negedge ck_t);
    chk("ovr_sticky", ovr2, 1);
    ddr_reset_n = 1'b0;
    #1;
    chk("ovr_reset", ovr2, 0);
    @(negedge ck_t);
    ddr_reset_n = 1'b1;
    @(negedge ck_t);

    chk("cas_count", cas_seen, C * n_req);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/gp_lpddr5_cmd_scheduler.md
# gp_lpddr5_cmd_scheduler

Single-rank, single-bank LPDDR5 command scheduler that turns read/write requests from the controller side into CS/CA command sequences on the channel interface (`gp_LPDDR5_channel_intf`). It keeps one row open and issues PRE/ACT as needed. It inserts periodic REF at idle points and enforces tRP, tRCD and tRFC. It is the sequencing source that the channel assertions (CAS→WR/RD, ACT→REF spacing, refresh interval) check.

## Interface
Parameters:
- T_RCD, 4, minimum cycles from ACT2 to CAS (or to RD/WR if CAS is compiled out); must be ≥1
- T_RP, 3, minimum cycles from PRE to ACT1 or REF; must be ≥1
- T_RFC, 8, cycles from REF until the next command is allowed; must be ≥1
- T_REFI, 64, refresh interval in cycles; must be ≥ T_RFC+8

Ports:
- ck_t, in, 1, command clock; all logic on its rising edge
- ddr_reset_n, in, 1, asynchronous active-low reset
- req_valid, in, 1, request present
- req_ready, out, 1, scheduler can accept a request
- req_op, in, 1, 0 = read, 1 = write
- req_row, in, 8, row address
- req_col, in, 4, column address
- cs, out, 1, chip select; drives cs0
- ca, out, 7, command/address; ca[6] is CA0 and ca[0] is CA6
- rw_issue, out, 1, one-cycle pulse coincident with the RD16/WR16 command
- rw_op, out, 1, op of the current rw_issue; valid only while rw_issue=1
- row_open, out, 1, a row is currently open
- ref_busy, out, 1, a refresh sequence (PRE/REF/tRFC) is in progress
- ref_overrun, out, 1, sticky flag: the refresh interval expired again while a refresh was still pending

## Operation
- Command encodings, listed as CA0..CA6:
  - ACT1 = 111,row[7:4]
  - ACT2 = 110,row[3:0]
  - PRE = 0001111
  - REF = 0001110
  - CAS_WR = 0011100
  - CAS_RD = 0011010
  - WR16 = 011,col
  - RD16 = 100,col
- Idle cycles drive cs=0 and ca=0.
- States: IDLE, PRE, TRP_WAIT, ACT1, ACT2, TRCD_WAIT, CAS, RW, REF, TRFC_WAIT.
- req_ready = (state==IDLE) && !ref_pending. A handshake captures op, row and col.
- Routing from IDLE after a handshake:
  - Row hit (row_open and the open row equals req_row): go to CAS.
  - Row closed: go to ACT1.
  - Row conflict: go to PRE → TRP_WAIT → ACT1.
- After ACT1: ACT2 → TRCD_WAIT → CAS → RW → IDLE.
- The page policy is open-page. After ACT2, row_open=1 and the open row = req_row.
- Refresh counter:
  - Free-runs from 0 to T_REFI-1, then wraps.
  - At wrap it sets ref_pending, which is a register.
  - If it wraps while ref_pending is already 1, ref_overrun is set.
- Refresh sequence, entered from IDLE when ref_pending=1:
  - If row_open, go PRE → TRP_WAIT first.
  - Then REF → TRFC_WAIT → IDLE.
  - ref_pending clears when REF is issued; row_open clears at PRE.
  - ref_busy=1 from entry until the return to IDLE.
- Simultaneous events: if the counter wraps in the same cycle that a handshake completes, the request is serviced first and refresh follows at the next IDLE.
- rw_op holds the captured op.

## Timing
- All outputs are registered.
- Cycle numbering: a handshake sampled at edge a makes the first command visible during cycle a+1. Each command is one cycle wide.
- Row hit: CAS at a+1, RD/WR at a+2.
- Row closed: ACT1 at a+1, ACT2 at a+2, CAS at a+2+T_RCD, RD/WR at a+3+T_RCD.
- Row conflict: PRE at a+1, ACT1 at a+1+T_RP, ACT2 at a+2+T_RP, CAS at a+2+T_RP+T_RCD, RD/WR one cycle later.
- Back-to-back: the scheduler returns to IDLE the cycle after RW, so req_ready=1 in that cycle. The minimum spacing between two RW commands on row hits is 3 cycles.
- Refresh: REF is issued at the first IDLE+1 cycle, or T_RP cycles after PRE if a row was open. req_ready reasserts T_RFC cycles after REF.
- CAS is always immediately followed by RD/WR, with no gap.
- Reset values: req_ready=0 during reset and 1 in the first cycle after release. cs, ca, rw_issue, rw_op, row_open, ref_busy and ref_overrun are all 0. The counter and ref_pending are 0.
- Reset asserted mid-sequence: outputs take their reset values immediately (asynchronously). No partial command is completed and row_open is lost.

## Configuration
- GP_LPDDR5_SCHED_CAS_SYNC_EN defined: the CAS_WR or CAS_RD cycle precedes every WR16/RD16, as timed above.
- Not defined: the CAS state is skipped, so every RD/WR timing above is one cycle earlier. No CAS encoding ever appears.

## Test plan
Defaults apply unless stated; the macro is defined unless stated.
- Row closed, read row=0x5A col=0x3 accepted at cycle 10 → ACT1 ca=1110101 at 11, ACT2 ca=1101010 at 12, CAS_RD at 16, RD16 ca=1000011 at 17 with rw_issue=1 and rw_op=0.
- Write to row 0x5A, then a write to row 0x21 → PRE at a+1, ACT1 at a+4, ACT2 at a+5, CAS_WR at a+9, WR16 at a+10, then row_open=1.
- T_REFI=64 with no traffic → REF every 64 cycles, ref_busy high for 1+T_RFC cycles, and req_ready low during that window.
- Refresh becomes pending while a row is open → PRE, then REF exactly T_RP cycles later, then row_open=0.
- Hold ready low with back-to-back conflicting requests until T_REFI wraps twice with ref_pending still set → ref_overrun=1 and it stays set until reset.
- Assert ddr_reset_n low during TRCD_WAIT → cs=0, ca=0 and row_open=0 immediately. After release, a row-hit read is treated as closed and issues ACT1 first.
- Macro undefined, row hit read at a → RD16 at a+1, and ca never equals 0011010.
